// File: rtl/regfile_pkg.sv
// Shared register-file write types and constants.
package regfile_pkg;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned ZERO_REG = 31;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   // One register-file write: destination and value.
   typedef struct packed {
      logic [ADDR_W-1:0] add;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   // True when the address is the hard-wired zero register.
   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return a == ADDR_W'(ZERO_REG);
   endfunction

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO buffering multi-cycle results awaiting the write port.
module wr_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  wr_req_t                  i_push_req,
   input  logic                     i_pop,
   output wr_req_t                  o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wr_req_t          r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage needs no reset: contents are only visible through a non-zero count.
   always_ff @(posedge clock) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_req;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between pipeline writeback and
// multi-cycle results, and tracks pending multi-cycle destinations.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         pipe_wr_en,
   input  logic [ADDR_W-1:0]            pipe_wr_add,
   input  logic [DATA_W-1:0]            pipe_wr_data,
   input  logic                         mc_valid,
   output logic                         mc_ready,
   input  logic [ADDR_W-1:0]            mc_add,
   input  logic [DATA_W-1:0]            mc_data,
   input  logic                         issue_en,
   input  logic [ADDR_W-1:0]            issue_add,
   input  logic [ADDR_W-1:0]            chk_add1,
   input  logic [ADDR_W-1:0]            chk_add2,
   input  logic [ADDR_W-1:0]            chk_dst,
   output logic                         stall,
   output logic                         rf_write_en,
   output logic [ADDR_W-1:0]            rf_write_add,
   output logic [DATA_W-1:0]            rf_write_data,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [CNT_W-1:0]    w_count;
   wr_req_t             w_head;
   wr_req_t             w_mc_req;
   logic                w_fifo_empty;
   logic                w_handshake;
   logic                w_pipe_take;
   logic                w_pop;
   logic                w_bypass;
   logic                w_push;
   logic                w_wr_en;
   wr_req_t             w_wr_req;
   logic                w_clr_en;
   logic [ADDR_W-1:0]   w_clr_add;
   logic [NUM_REGS-1:0] w_busy_nxt;

   logic                r_wr_en;
   wr_req_t             r_wr_req;
   logic [NUM_REGS-1:0] r_busy;

   assign w_mc_req     = '{add: mc_add, data: mc_data};
   assign w_fifo_empty = (w_count == '0);
   assign mc_ready     = (w_count < CNT_W'(FIFO_DEPTH));
   assign w_handshake  = mc_valid & mc_ready;
   assign w_pipe_take  = pipe_wr_en & ~is_zero_reg(pipe_wr_add);
   assign w_push       = w_handshake & ~w_bypass;

   u_fifo_t_unused_guard: assert property (@(posedge clock) disable iff (!reset_n)
      !(w_pop && w_fifo_empty));

   wr_fifo #(
      .DEPTH      (FIFO_DEPTH)
   ) u_wr_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_push     (w_push),
      .i_push_req (w_mc_req),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_count    (w_count)
   );

   // Fixed-priority grant: pipeline, then buffered result, then bypass.
   // A zero-register destination is consumed without driving the port.
   always_comb begin
      w_pop     = 1'b0;
      w_bypass  = 1'b0;
      w_wr_en   = 1'b0;
      w_wr_req  = '0;
      w_clr_en  = 1'b0;
      w_clr_add = '0;
      if (w_pipe_take) begin
         w_wr_en  = 1'b1;
         w_wr_req = '{add: pipe_wr_add, data: pipe_wr_data};
      end else if (!w_fifo_empty) begin
         w_pop     = 1'b1;
         w_wr_en   = ~is_zero_reg(w_head.add);
         w_wr_req  = w_head;
         w_clr_en  = 1'b1;
         w_clr_add = w_head.add;
      end else if (w_handshake) begin
         w_bypass  = 1'b1;
         w_wr_en   = ~is_zero_reg(mc_add);
         w_wr_req  = w_mc_req;
         w_clr_en  = 1'b1;
         w_clr_add = mc_add;
      end
   end

   // Registered write port; address and data hold when idle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_en  <= 1'b0;
         r_wr_req <= '0;
      end else begin
         r_wr_en <= w_wr_en;
         if (w_wr_en) r_wr_req <= w_wr_req;
      end
   end

   // Busy update: clear on grant, then set on issue so a same-cycle reissue wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_clr_en) w_busy_nxt[w_clr_add] = 1'b0;
      if (issue_en) w_busy_nxt[issue_add] = 1'b1;
      w_busy_nxt[ZERO_REG] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_busy <= '0;
      else          r_busy <= w_busy_nxt;
   end

   assign stall         = r_busy[chk_add1] | r_busy[chk_add2] | r_busy[chk_dst];
   assign rf_write_en   = r_wr_en;
   assign rf_write_add  = r_wr_req.add;
   assign rf_write_data = r_wr_req.data;
   assign fifo_count    = w_count;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, reset corner, and
// randomized traffic against a queue-based reference model.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              pipe_wr_en;
   logic [4:0]        pipe_wr_add;
   logic [63:0]       pipe_wr_data;
   logic              mc_valid;
   logic              mc_ready;
   logic [4:0]        mc_add;
   logic [63:0]       mc_data;
   logic              issue_en;
   logic [4:0]        issue_add;
   logic [4:0]        chk_add1;
   logic [4:0]        chk_add2;
   logic [4:0]        chk_dst;
   logic              stall;
   logic              rf_write_en;
   logic [4:0]        rf_write_add;
   logic [63:0]       rf_write_data;
   logic [1:0]        fifo_count;

   int n_checks = 0;
   int n_errors = 0;

   regfile_wr_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .pipe_wr_en(pipe_wr_en), .pipe_wr_add(pipe_wr_add), .pipe_wr_data(pipe_wr_data),
      .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_add(mc_add), .mc_data(mc_data),
      .issue_en(issue_en), .issue_add(issue_add),
      .chk_add1(chk_add1), .chk_add2(chk_add2), .chk_dst(chk_dst), .stall(stall),
      .rf_write_en(rf_write_en), .rf_write_add(rf_write_add), .rf_write_data(rf_write_data),
      .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      pipe_wr_en = 0; pipe_wr_add = 0; pipe_wr_data = 0;
      mc_valid = 0; mc_add = 0; mc_data = 0;
      issue_en = 0; issue_add = 0;
      chk_add1 = 0; chk_add2 = 0; chk_dst = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic pe; logic [4:0] pa; logic [63:0] pd;
      logic mv; logic [4:0] ma; logic [63:0] md;
      logic ie; logic [4:0] ia;
      logic [4:0] c1; logic [4:0] c2; logic [4:0] cd;
      logic er; logic es;
      logic ee; logic [4:0] ea; logic [63:0] ed; logic [1:0] ec;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic pe, input logic [4:0] pa, input logic [63:0] pd,
      input logic mv, input logic [4:0] ma, input logic [63:0] md,
      input logic ie, input logic [4:0] ia,
      input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cd,
      input logic er, input logic es,
      input logic ee, input logic [4:0] ea, input logic [63:0] ed, input logic [1:0] ec);
      vec_t v;
      v.pe = pe; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
      v.ie = ie; v.ia = ia; v.c1 = c1; v.c2 = c2; v.cd = cd;
      v.er = er; v.es = es; v.ee = ee; v.ea = ea; v.ed = ed; v.ec = ec;
      return v;
   endfunction

   task automatic apply_vec(input int idx, input vec_t v);
      pipe_wr_en = v.pe; pipe_wr_add = v.pa; pipe_wr_data = v.pd;
      mc_valid = v.mv; mc_add = v.ma; mc_data = v.md;
      issue_en = v.ie; issue_add = v.ia;
      chk_add1 = v.c1; chk_add2 = v.c2; chk_dst = v.cd;
      #1;
      check($sformatf("vec%0d_mc_ready", idx), 64'(mc_ready), 64'(v.er));
      check($sformatf("vec%0d_stall", idx), 64'(stall), 64'(v.es));
      @(posedge clock); #1;
      check($sformatf("vec%0d_wr_en", idx), 64'(rf_write_en), 64'(v.ee));
      check($sformatf("vec%0d_wr_add", idx), 64'(rf_write_add), 64'(v.ea));
      check($sformatf("vec%0d_wr_data", idx), rf_write_data, v.ed);
      check($sformatf("vec%0d_count", idx), 64'(fifo_count), 64'(v.ec));
   endtask

   // ---------------- reference model ----------------
   wr_req_t     m_q[$];
   bit          m_busy[32];
   logic        m_en;
   logic [4:0]  m_add;
   logic [63:0] m_data;

   task automatic model_reset();
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_en = 0; m_add = 0; m_data = 0;
   endtask

   function automatic bit model_stall();
      return m_busy[chk_add1] || m_busy[chk_add2] || m_busy[chk_dst];
   endfunction

   // One clock of the arbitration rules, using the current input values.
   task automatic model_step();
      bit accepted;
      bit bypassed;
      wr_req_t r;
      accepted = mc_valid && (m_q.size() < DEPTH);
      bypassed = 0;
      m_en = 0;
      if (pipe_wr_en && pipe_wr_add != 5'd31) begin
         m_en = 1; m_add = pipe_wr_add; m_data = pipe_wr_data;
      end else if (m_q.size() > 0) begin
         r = m_q.pop_front();
         m_busy[r.add] = 0;
         if (r.add != 5'd31) begin m_en = 1; m_add = r.add; m_data = r.data; end
      end else if (accepted) begin
         bypassed = 1;
         m_busy[mc_add] = 0;
         if (mc_add != 5'd31) begin m_en = 1; m_add = mc_add; m_data = mc_data; end
      end
      if (accepted && !bypassed) m_q.push_back('{add: mc_add, data: mc_data});
      if (issue_en && issue_add != 5'd31) m_busy[issue_add] = 1;
   endtask

   task automatic rand_cycle(input int idx);
      pipe_wr_en   = ($urandom_range(0, 3) != 0);
      pipe_wr_add  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      pipe_wr_data = {$urandom, $urandom};
      mc_valid     = ($urandom_range(0, 1) == 1);
      mc_add       = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom);
      mc_data      = {$urandom, $urandom};
      issue_add    = 5'($urandom);
      issue_en     = ($urandom_range(0, 2) == 0) && !m_busy[issue_add];
      chk_add1     = 5'($urandom);
      chk_add2     = 5'($urandom);
      chk_dst      = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom);
      #1;
      check($sformatf("rnd%0d_mc_ready", idx), 64'(mc_ready), 64'(m_q.size() < DEPTH));
      check($sformatf("rnd%0d_stall", idx), 64'(stall), 64'(model_stall()));
      model_step();
      @(posedge clock); #1;
      check($sformatf("rnd%0d_wr_en", idx), 64'(rf_write_en), 64'(m_en));
      check($sformatf("rnd%0d_wr_add", idx), 64'(rf_write_add), 64'(m_add));
      check($sformatf("rnd%0d_wr_data", idx), rf_write_data, m_data);
      check($sformatf("rnd%0d_count", idx), 64'(fifo_count), 64'(m_q.size()));
   endtask

   initial begin
      reset_n = 0;
      idle_inputs();
      #1;
      check("reset_wr_en", 64'(rf_write_en), 64'd0);
      check("reset_wr_add", 64'(rf_write_add), 64'd0);
      check("reset_wr_data", rf_write_data, 64'd0);
      check("reset_count", 64'(fifo_count), 64'd0);
      check("reset_mc_ready", 64'(mc_ready), 64'd1);
      check("reset_stall", 64'(stall), 64'd0);
      repeat (2) @(posedge clock);
      #2 reset_n = 1;
      @(posedge clock); #1;

      // pe pa pd | mv ma md | ie ia | c1 c2 cd | er es | ee ea ed ec
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       1, 5,  5, 0, 0,    1, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  5, 0, 0,    1, 1,  0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,     1, 5, 'hAB,    0, 0,  5, 0, 0,    1, 1,  1, 5, 'hAB, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  5, 0, 0,    1, 0,  0, 5, 'hAB, 0));
      vecs.push_back(mk(1, 3, 7,     1, 4, 9,       0, 0,  0, 0, 0,    1, 0,  1, 3, 7, 1));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  0, 0, 0,    1, 0,  1, 4, 9, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  0, 0, 0,    1, 0,  0, 4, 9, 0));
      vecs.push_back(mk(1, 1, 'h11,  1, 10, 'hA0,   0, 0,  0, 0, 0,    1, 0,  1, 1, 'h11, 1));
      vecs.push_back(mk(1, 2, 'h22,  1, 11, 'hA1,   0, 0,  0, 0, 0,    1, 0,  1, 2, 'h22, 2));
      vecs.push_back(mk(1, 1, 'h33,  1, 12, 'hA2,   0, 0,  0, 0, 0,    0, 0,  1, 1, 'h33, 2));
      vecs.push_back(mk(0, 0, 0,     1, 12, 'hA2,   0, 0,  0, 0, 0,    0, 0,  1, 10, 'hA0, 1));
      vecs.push_back(mk(0, 0, 0,     1, 12, 'hA2,   0, 0,  0, 0, 0,    1, 0,  1, 11, 'hA1, 1));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  0, 0, 0,    1, 0,  1, 12, 'hA2, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  0, 0, 0,    1, 0,  0, 12, 'hA2, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       1, 8,  8, 0, 0,    1, 0,  0, 12, 'hA2, 0));
      vecs.push_back(mk(0, 0, 0,     1, 8, 'h80,    1, 8,  8, 0, 0,    1, 1,  1, 8, 'h80, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  0, 0, 8,    1, 1,  0, 8, 'h80, 0));
      vecs.push_back(mk(0, 0, 0,     1, 8, 'h81,    0, 0,  0, 8, 0,    1, 1,  1, 8, 'h81, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  8, 0, 0,    1, 0,  0, 8, 'h81, 0));
      vecs.push_back(mk(1, 1, 1,     1, 6, 'h66,    1, 6,  31, 31, 31, 1, 0,  1, 1, 1, 1));
      vecs.push_back(mk(1, 31, 'hFF, 0, 0, 0,       0, 0,  6, 6, 6,    1, 1,  1, 6, 'h66, 0));
      vecs.push_back(mk(1, 31, 'hEE, 0, 0, 0,       0, 0,  6, 0, 0,    1, 0,  0, 6, 'h66, 0));
      vecs.push_back(mk(0, 0, 0,     1, 31, 'h31,   1, 31, 31, 31, 31, 1, 0,  0, 6, 'h66, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0,  31, 0, 0,   1, 0,  0, 6, 'h66, 0));

      foreach (vecs[i]) apply_vec(i, vecs[i]);

      // Reset in the middle of a burst with a full buffer and a busy register.
      pipe_wr_en = 1; pipe_wr_add = 1; pipe_wr_data = 1;
      mc_valid = 1; mc_add = 13; mc_data = 'hD0;
      issue_en = 1; issue_add = 9;
      @(posedge clock); #1;
      pipe_wr_add = 2; mc_add = 14; mc_data = 'hD1; issue_en = 0;
      chk_add1 = 9;
      @(posedge clock); #1;
      check("burst_count_full", 64'(fifo_count), 64'd2);
      check("burst_mc_ready", 64'(mc_ready), 64'd0);
      check("burst_stall", 64'(stall), 64'd1);
      pipe_wr_add = 3; mc_add = 15;
      #2 reset_n = 0;
      #1;
      check("midrst_wr_en", 64'(rf_write_en), 64'd0);
      check("midrst_count", 64'(fifo_count), 64'd0);
      check("midrst_stall", 64'(stall), 64'd0);
      check("midrst_mc_ready", 64'(mc_ready), 64'd1);
      @(posedge clock); #1;
      check("midrst_held_wr_en", 64'(rf_write_en), 64'd0);
      check("midrst_held_count", 64'(fifo_count), 64'd0);
      idle_inputs();
      #2 reset_n = 1;
      model_reset();
      @(posedge clock); #1;

      for (int i = 0; i < 3000; i++) rand_cycle(i);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
